// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the IFU (master 0)
// and the LSU (master 1), one outstanding transaction, with a response watchdog.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clock,
    input  logic                reset,

    input  logic                io_m0_req_valid,
    output logic                io_m0_req_ready,
    input  logic [ADDR_W-1:0]   io_m0_req_addr,
    output logic                io_m0_resp_valid,
    input  logic                io_m0_resp_ready,
    output logic [DATA_W-1:0]   io_m0_resp_rdata,
    output logic                io_m0_resp_err,

    input  logic                io_m1_req_valid,
    output logic                io_m1_req_ready,
    input  logic [ADDR_W-1:0]   io_m1_req_addr,
    input  logic                io_m1_req_wen,
    input  logic [DATA_W-1:0]   io_m1_req_wdata,
    input  logic [DATA_W/8-1:0] io_m1_req_wstrb,
    output logic                io_m1_resp_valid,
    input  logic                io_m1_resp_ready,
    output logic [DATA_W-1:0]   io_m1_resp_rdata,
    output logic                io_m1_resp_err,

    output logic                io_mem_req_valid,
    input  logic                io_mem_req_ready,
    output logic [ADDR_W-1:0]   io_mem_req_addr,
    output logic                io_mem_req_wen,
    output logic [DATA_W-1:0]   io_mem_req_wdata,
    output logic [DATA_W/8-1:0] io_mem_req_wstrb,
    input  logic                io_mem_resp_valid,
    output logic                io_mem_resp_ready,
    input  logic [DATA_W-1:0]   io_mem_resp_rdata,

    output logic                io_busy
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        WAIT,
        ERR
    } state_t;

    state_t        state;
    logic          grant;
    logic          lastGrant;
    logic [CW-1:0] waitCnt;
    logic          grantedRespReady;

    assign grantedRespReady = grant ? io_m1_resp_ready : io_m0_resp_ready;
    assign io_busy          = (state != IDLE);

    // waitCnt counts WAIT cycles already spent; ERR is taken on the TIMEOUT-th
    // empty WAIT cycle, and the count saturates so a long-held response cannot wrap it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            grant     <= 1'b0;
            lastGrant <= 1'b1;
            waitCnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (io_m0_req_valid || io_m1_req_valid) begin
                        grant <= (io_m0_req_valid && io_m1_req_valid) ? ~lastGrant
                                                                       : io_m1_req_valid;
                        state <= ADDR;
                    end
                end
                ADDR: begin
                    if (io_mem_req_ready) begin
                        state   <= WAIT;
                        waitCnt <= '0;
                    end
                end
                WAIT: begin
                    if (io_mem_resp_valid && grantedRespReady) begin
                        lastGrant <= grant;
                        state     <= IDLE;
                    end else begin
                        if (!io_mem_resp_valid && waitCnt >= LAST_CNT) begin
                            state <= ERR;
                        end
                        if (waitCnt < LAST_CNT) begin
                            waitCnt <= waitCnt + CW'(1);
                        end
                    end
                end
                ERR: begin
                    if (grantedRespReady) begin
                        lastGrant <= grant;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode from the registered state; the memory response passes
    // straight through to the granted master while waiting.
    always_comb begin
        io_m0_req_ready   = 1'b0;
        io_m1_req_ready   = 1'b0;
        io_m0_resp_valid  = 1'b0;
        io_m1_resp_valid  = 1'b0;
        io_m0_resp_rdata  = '0;
        io_m1_resp_rdata  = '0;
        io_m0_resp_err    = 1'b0;
        io_m1_resp_err    = 1'b0;
        io_mem_req_valid  = 1'b0;
        io_mem_req_addr   = '0;
        io_mem_req_wen    = 1'b0;
        io_mem_req_wdata  = '0;
        io_mem_req_wstrb  = '0;
        io_mem_resp_ready = 1'b0;

        case (state)
            ADDR: begin
                io_mem_req_valid = 1'b1;
                if (grant) begin
                    io_mem_req_addr  = io_m1_req_addr;
                    io_mem_req_wen   = io_m1_req_wen;
                    io_mem_req_wdata = io_m1_req_wdata;
                    io_mem_req_wstrb = io_m1_req_wstrb;
                    io_m1_req_ready  = io_mem_req_ready;
                end else begin
                    io_mem_req_addr  = io_m0_req_addr;
                    io_m0_req_ready  = io_mem_req_ready;
                end
            end
            WAIT: begin
                io_mem_resp_ready = grantedRespReady;
                if (grant) begin
                    io_m1_resp_valid = io_mem_resp_valid;
                    io_m1_resp_rdata = io_mem_resp_rdata;
                end else begin
                    io_m0_resp_valid = io_mem_resp_valid;
                    io_m0_resp_rdata = io_mem_resp_rdata;
                end
            end
            ERR: begin
                io_mem_resp_ready = 1'b1;
                if (grant) begin
                    io_m1_resp_valid = 1'b1;
                    io_m1_resp_err   = 1'b1;
                end else begin
                    io_m0_resp_valid = 1'b1;
                    io_m0_resp_err   = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Cycle-vector testbench for mem_arbiter: a table of per-cycle stimulus and
// expected outputs, plus hand sequences for watchdog timeout and async reset.
module tb_mem_arbiter;

    localparam int TO = 4;
    localparam logic [31:0] M0_ADDR  = 32'h8000_0000;
    localparam logic [31:0] M1_ADDR  = 32'h8000_1000;
    localparam logic [31:0] M1_WDATA = 32'hDEAD_BEEF;
    localparam logic [3:0]  M1_WSTRB = 4'b0011;

    // Control word: {busy, memReqV, m0ReqRdy, m1ReqRdy, memRespRdy, m0RespV, m1RespV, m0Err, m1Err}
    localparam logic [8:0] C_IDLE        = 9'b0_0_0_0_0_0_0_0_0;
    localparam logic [8:0] C_ADDR0       = 9'b1_1_1_0_0_0_0_0_0;
    localparam logic [8:0] C_ADDR1       = 9'b1_1_0_1_0_0_0_0_0;
    localparam logic [8:0] C_ADDR_STALL  = 9'b1_1_0_0_0_0_0_0_0;
    localparam logic [8:0] C_WAIT0_RESP  = 9'b1_0_0_0_1_1_0_0_0;
    localparam logic [8:0] C_WAIT1_RESP  = 9'b1_0_0_0_1_0_1_0_0;
    localparam logic [8:0] C_WAIT1_STALL = 9'b1_0_0_0_0_0_1_0_0;
    localparam logic [8:0] C_WAIT0_NORDY = 9'b1_0_0_0_0_1_0_0_0;
    localparam logic [8:0] C_WAIT_EMPTY  = 9'b1_0_0_0_0_0_0_0_0;
    localparam logic [8:0] C_ERR0        = 9'b1_0_0_0_1_1_0_1_0;

    logic        clock;
    logic        reset;
    logic        io_m0_req_valid, io_m0_req_ready, io_m0_resp_valid, io_m0_resp_ready, io_m0_resp_err;
    logic [31:0] io_m0_req_addr, io_m0_resp_rdata;
    logic        io_m1_req_valid, io_m1_req_ready, io_m1_req_wen, io_m1_resp_valid, io_m1_resp_ready, io_m1_resp_err;
    logic [31:0] io_m1_req_addr, io_m1_req_wdata, io_m1_resp_rdata;
    logic [3:0]  io_m1_req_wstrb;
    logic        io_mem_req_valid, io_mem_req_ready, io_mem_req_wen, io_mem_resp_valid, io_mem_resp_ready;
    logic [31:0] io_mem_req_addr, io_mem_req_wdata, io_mem_resp_rdata;
    logic [3:0]  io_mem_req_wstrb;
    logic        io_busy;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clock            (clock),
        .reset            (reset),
        .io_m0_req_valid  (io_m0_req_valid),
        .io_m0_req_ready  (io_m0_req_ready),
        .io_m0_req_addr   (io_m0_req_addr),
        .io_m0_resp_valid (io_m0_resp_valid),
        .io_m0_resp_ready (io_m0_resp_ready),
        .io_m0_resp_rdata (io_m0_resp_rdata),
        .io_m0_resp_err   (io_m0_resp_err),
        .io_m1_req_valid  (io_m1_req_valid),
        .io_m1_req_ready  (io_m1_req_ready),
        .io_m1_req_addr   (io_m1_req_addr),
        .io_m1_req_wen    (io_m1_req_wen),
        .io_m1_req_wdata  (io_m1_req_wdata),
        .io_m1_req_wstrb  (io_m1_req_wstrb),
        .io_m1_resp_valid (io_m1_resp_valid),
        .io_m1_resp_ready (io_m1_resp_ready),
        .io_m1_resp_rdata (io_m1_resp_rdata),
        .io_m1_resp_err   (io_m1_resp_err),
        .io_mem_req_valid (io_mem_req_valid),
        .io_mem_req_ready (io_mem_req_ready),
        .io_mem_req_addr  (io_mem_req_addr),
        .io_mem_req_wen   (io_mem_req_wen),
        .io_mem_req_wdata (io_mem_req_wdata),
        .io_mem_req_wstrb (io_mem_req_wstrb),
        .io_mem_resp_valid(io_mem_resp_valid),
        .io_mem_resp_ready(io_mem_resp_ready),
        .io_mem_resp_rdata(io_mem_resp_rdata),
        .io_busy          (io_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // stim = {m0v, m1v, memReqRdy, memRespV, m0RespRdy, m1RespRdy}; expSel 0=none, 1=IFU, 2=LSU
    typedef struct {
        string       name;
        logic [5:0]  stim;
        logic [31:0] memRd;
        logic [8:0]  expCtl;
        logic [1:0]  expSel;
        logic [31:0] expRd0;
        logic [31:0] expRd1;
    } vec_t;

    vec_t vecs[$];
    int   testsRun    = 0;
    int   testsFailed = 0;

    task automatic addVec(input string name, input logic [5:0] stim, input logic [31:0] memRd,
                          input logic [8:0] expCtl, input logic [1:0] expSel,
                          input logic [31:0] expRd0, input logic [31:0] expRd1);
        vec_t v;
        v.name   = name;
        v.stim   = stim;
        v.memRd  = memRd;
        v.expCtl = expCtl;
        v.expSel = expSel;
        v.expRd0 = expRd0;
        v.expRd1 = expRd1;
        vecs.push_back(v);
    endtask

    task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic setInputs(input logic [5:0] stim, input logic [31:0] memRd);
        {io_m0_req_valid, io_m1_req_valid, io_mem_req_ready,
         io_mem_resp_valid, io_m0_resp_ready, io_m1_resp_ready} = stim;
        io_mem_resp_rdata = memRd;
    endtask

    // Drive just after the rising edge, then settle to the falling edge for sampling.
    task automatic applyStimulus(input logic [5:0] stim, input logic [31:0] memRd);
        @(posedge clock);
        #1;
        setInputs(stim, memRd);
        @(negedge clock);
    endtask

    task automatic checkOutput(input string name, input logic [8:0] expCtl, input logic [1:0] expSel,
                               input logic [31:0] expRd0, input logic [31:0] expRd1);
        logic [31:0] expAddr;
        logic [31:0] expWdata;
        logic [4:0]  expWenStrb;
        logic [8:0]  actCtl;
        expAddr    = '0;
        expWdata   = '0;
        expWenStrb = '0;
        if (expSel == 2'd1) begin
            expAddr = M0_ADDR;
        end else if (expSel == 2'd2) begin
            expAddr    = M1_ADDR;
            expWdata   = M1_WDATA;
            expWenStrb = {1'b1, M1_WSTRB};
        end
        actCtl = {io_busy, io_mem_req_valid, io_m0_req_ready, io_m1_req_ready, io_mem_resp_ready,
                  io_m0_resp_valid, io_m1_resp_valid, io_m0_resp_err, io_m1_resp_err};
        checkEq({name, ".ctl"},   {23'd0, actCtl}, {23'd0, expCtl});
        checkEq({name, ".addr"},  io_mem_req_addr, expAddr);
        checkEq({name, ".wdata"}, io_mem_req_wdata, expWdata);
        checkEq({name, ".wstrb"}, {27'd0, io_mem_req_wen, io_mem_req_wstrb}, {27'd0, expWenStrb});
        checkEq({name, ".rd0"},   io_m0_resp_rdata, expRd0);
        checkEq({name, ".rd1"},   io_m1_resp_rdata, expRd1);
    endtask

    initial begin
        reset           = 1'b0;
        io_m0_req_addr  = M0_ADDR;
        io_m1_req_addr  = M1_ADDR;
        io_m1_req_wen   = 1'b1;
        io_m1_req_wdata = M1_WDATA;
        io_m1_req_wstrb = M1_WSTRB;
        setInputs(6'b111111, 32'h5555_5555);

        // Round robin: both held valid, zero-wait memory, first tie to IFU
        for (int t = 0; t < 2; t++) begin
            addVec("rr_idle0",  6'b111111, 32'hA5A5_A5A5, C_IDLE,       2'd0, 32'h0,          32'h0);
            addVec("rr_addr0",  6'b111111, 32'hA5A5_A5A5, C_ADDR0,      2'd1, 32'h0,          32'h0);
            addVec("rr_wait0",  6'b111111, 32'hA5A5_A5A5, C_WAIT0_RESP, 2'd0, 32'hA5A5_A5A5, 32'h0);
            addVec("rr_idle1",  6'b111111, 32'hA5A5_A5A5, C_IDLE,       2'd0, 32'h0,          32'h0);
            addVec("rr_addr1",  6'b111111, 32'hA5A5_A5A5, C_ADDR1,      2'd2, 32'h0,          32'h0);
            addVec("rr_wait1",  6'b111111, 32'hA5A5_A5A5, C_WAIT1_RESP, 2'd0, 32'h0,          32'hA5A5_A5A5);
        end
        addVec("rr_done",       6'b000011, 32'h0,         C_IDLE,       2'd0, 32'h0,          32'h0);
        // IFU-only read, three cycles valid to response handshake
        addVec("ifu_idle",      6'b101011, 32'h0,         C_IDLE,       2'd0, 32'h0,          32'h0);
        addVec("ifu_addr",      6'b101011, 32'h0,         C_ADDR0,      2'd1, 32'h0,          32'h0);
        addVec("ifu_wait",      6'b000111, 32'h0000_0413, C_WAIT0_RESP, 2'd0, 32'h0000_0413, 32'h0);
        addVec("ifu_done",      6'b000011, 32'h0,         C_IDLE,       2'd0, 32'h0,          32'h0);
        // LSU write with request then response backpressure
        addVec("bp_idle",       6'b010011, 32'h0,         C_IDLE,       2'd0, 32'h0,          32'h0);
        for (int i = 0; i < 5; i++)
            addVec("bp_addr_stall", 6'b010011, 32'h0,     C_ADDR_STALL, 2'd2, 32'h0,          32'h0);
        addVec("bp_addr_go",    6'b011011, 32'h0,         C_ADDR1,      2'd2, 32'h0,          32'h0);
        for (int i = 0; i < 3; i++)
            addVec("bp_wait_stall", 6'b000110, 32'hCAFE_F00D, C_WAIT1_STALL, 2'd0, 32'h0,     32'hCAFE_F00D);
        addVec("bp_wait_go",    6'b000111, 32'hCAFE_F00D, C_WAIT1_RESP, 2'd0, 32'h0,          32'hCAFE_F00D);
        addVec("bp_done",       6'b000011, 32'h0,         C_IDLE,       2'd0, 32'h0,          32'h0);

        @(negedge clock);
        checkOutput("reset", C_IDLE, 2'd0, 32'h0, 32'h0);
        setInputs(6'b000000, 32'h0);
        reset = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].stim, vecs[i].memRd);
            checkOutput(vecs[i].name, vecs[i].expCtl, vecs[i].expSel, vecs[i].expRd0, vecs[i].expRd1);
        end

        // Watchdog: memory never answers, TO empty WAIT cycles then an error response
        applyStimulus(6'b101000, 32'h0);
        checkOutput("to_idle", C_IDLE, 2'd0, 32'h0, 32'h0);
        applyStimulus(6'b101000, 32'h0);
        checkOutput("to_addr", C_ADDR0, 2'd1, 32'h0, 32'h0);
        for (int i = 0; i < TO; i++) begin
            applyStimulus(6'b000000, 32'h0);
            checkOutput("to_wait", C_WAIT_EMPTY, 2'd0, 32'h0, 32'h0);
        end
        applyStimulus(6'b000100, 32'h1234_5678);
        checkOutput("to_err_hold", C_ERR0, 2'd0, 32'h0, 32'h0);
        applyStimulus(6'b000010, 32'h0);
        checkOutput("to_err_ack", C_ERR0, 2'd0, 32'h0, 32'h0);
        applyStimulus(6'b101011, 32'h0);
        checkOutput("to_next_idle", C_IDLE, 2'd0, 32'h0, 32'h0);
        applyStimulus(6'b101011, 32'h0);
        checkOutput("to_next_addr", C_ADDR0, 2'd1, 32'h0, 32'h0);
        applyStimulus(6'b000111, 32'h0000_0513);
        checkOutput("to_next_wait", C_WAIT0_RESP, 2'd0, 32'h0000_0513, 32'h0);

        // Async reset in WAIT after an IFU grant, so a plain tie would now favour the LSU
        applyStimulus(6'b101011, 32'h0);
        applyStimulus(6'b101011, 32'h0);
        checkOutput("rst_addr", C_ADDR0, 2'd1, 32'h0, 32'h0);
        applyStimulus(6'b000100, 32'h0000_0077);
        checkOutput("rst_wait", C_WAIT0_NORDY, 2'd0, 32'h0000_0077, 32'h0);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("rst_async", C_IDLE, 2'd0, 32'h0, 32'h0);
        applyStimulus(6'b111111, 32'h0000_0077);
        checkOutput("rst_hold", C_IDLE, 2'd0, 32'h0, 32'h0);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        checkOutput("rst_tie", C_ADDR0, 2'd1, 32'h0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
